// File: rtl/weight_buf_pkg.sv
// rtl/weight_buf_pkg.sv - shared sizing helpers and FSM state type for the weight ping-pong buffer
package weight_buf_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } wbuf_state_e;

    // Bits in one output-channel kernel set.
    function automatic int kset_w(input int num_channels, input int filter_size, input int data_width);
        return num_channels * filter_size * filter_size * data_width;
    endfunction

    // Bits in one bank line (all kernel sets side by side).
    function automatic int line_w(input int num_ksets, input int kset_width);
        return num_ksets * kset_width;
    endfunction

    // DMA beats needed to fill one line; a partial final beat still counts.
    function automatic int beats(input int line_width, input int axis_width);
        return (line_width + axis_width - 1) / axis_width;
    endfunction

    // Index width for a depth, never narrower than one bit.
    function automatic int addr_w(input int depth);
        return (depth <= 1) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/wbuf_bank_ram.sv
// rtl/wbuf_bank_ram.sv - simple dual-port line RAM with one write port and a registered read port
module wbuf_bank_ram #(
    parameter int W     = 1152,
    parameter int DEPTH = 512,
    parameter int AW    = 9
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    (* ram_style = "block" *) logic [W-1:0] mem [DEPTH];

    // Contents are deliberately not reset so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/weight_pingpong_buffer.sv
// rtl/weight_pingpong_buffer.sv - double-buffered weight store: DMA fills the back bank while the core reads the active one
module weight_pingpong_buffer
    import weight_buf_pkg::*;
#(
    parameter int AXIS_DATA_WIDTH = 64,
    parameter int NUM_CHANNELS    = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int FILTER_SIZE     = 3,
    parameter int NUM_KSETS       = 2,
    parameter int BANK_DEPTH      = 512,
    localparam int KSET_W = kset_w(NUM_CHANNELS, FILTER_SIZE, DATA_WIDTH),
    localparam int LINE_W = line_w(NUM_KSETS, KSET_W),
    localparam int AW     = addr_w(BANK_DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       s_axis_tvalid,
    output logic                       s_axis_tready,
    input  logic [AXIS_DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                       s_axis_tlast,
    input  logic                       i_load_start,
    input  logic                       i_swap,
    output logic                       o_load_done,
    output logic                       o_load_err,
    output logic [AW:0]                o_back_lines,
    output logic                       o_active_bank,
    input  logic                       i_read_en,
    input  logic [AW-1:0]              i_read_addr,
    output logic [LINE_W-1:0]          o_kernels_packed,
    output logic                       o_read_valid,
    output logic                       o_read_oob
);

    localparam int BEATS = beats(LINE_W, AXIS_DATA_WIDTH);
    localparam int ASM_W = BEATS * AXIS_DATA_WIDTH;
    localparam int BCW   = addr_w(BEATS);
    localparam int BLW   = AW + 1;

    wbuf_state_e state, state_next;

    logic [BCW-1:0]   beat_cnt;
    logic [ASM_W-1:0] asm_q;
    logic [ASM_W-1:0] asm_next;
    logic [BLW-1:0]   back_lines;
    logic [BLW-1:0]   active_lines;
    logic             active_bank;
    logic             load_done_q;
    logic             load_err_q;

    logic             swap_ok;
    logic             do_swap;
    logic             beat_fire;
    logic             last_slot;
    logic             line_end;
    logic             last_line;
    logic             finish_ok;
    logic             finish_err;
    int unsigned      slot_base;

    logic             we0;
    logic             we1;
    logic [LINE_W-1:0] wr_line;
    logic [LINE_W-1:0] rdata0;
    logic [LINE_W-1:0] rdata1;

    logic             rd_sel_q;
    logic             rd_zero_q;
    logic             read_valid_q;
    logic             read_oob_q;
    logic             rd_oob;

    assign s_axis_tready = (state == LOAD);
    assign o_load_done   = load_done_q;
    assign o_load_err    = load_err_q;
    assign o_back_lines  = back_lines;
    assign o_active_bank = active_bank;
    assign o_read_valid  = read_valid_q;
    assign o_read_oob    = read_oob_q;

    // Next state plus the per-cycle strobes that the datapath registers act on.
    always_comb begin
        state_next = state;
        swap_ok    = (state == DONE) || ((state == IDLE) && load_done_q);
        do_swap    = i_swap && swap_ok;
        beat_fire  = (state == LOAD) && s_axis_tvalid && !i_load_start;
        last_slot  = (beat_cnt == BCW'(BEATS - 1));
        line_end   = beat_fire && (s_axis_tlast || last_slot);
        last_line  = (back_lines == BLW'(BANK_DEPTH - 1));
        finish_ok  = line_end && s_axis_tlast && last_slot;
        finish_err = line_end && ((s_axis_tlast && !last_slot) || (last_line && !s_axis_tlast));
        case (state)
            IDLE, DONE: begin
                if (i_load_start) begin
                    state_next = LOAD;
                end else if (do_swap) begin
                    state_next = IDLE;
                end
            end
            LOAD: begin
                if (i_load_start) begin
                    state_next = LOAD;
                end else if (line_end && (s_axis_tlast || last_line)) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Assembly view with the in-flight beat dropped into its slot; slots above it are
    // already zero, so this is also the zero-padded line to write on completion.
    always_comb begin
        slot_base = int'(beat_cnt) * AXIS_DATA_WIDTH;
        asm_next  = asm_q;
        asm_next[slot_base +: AXIS_DATA_WIDTH] = s_axis_tdata;
        wr_line   = asm_next[LINE_W-1:0];
    end

    // The back bank is always the one the core is not reading.
    assign we0 = line_end && active_bank;
    assign we1 = line_end && !active_bank;

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Load bookkeeping and bank exchange; a swap and a start in the same cycle both apply.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt     <= '0;
            asm_q        <= '0;
            back_lines   <= '0;
            active_lines <= '0;
            active_bank  <= 1'b0;
            load_done_q  <= 1'b0;
            load_err_q   <= 1'b0;
        end else begin
            if (do_swap) begin
                active_bank  <= !active_bank;
                active_lines <= back_lines;
                load_done_q  <= 1'b0;
            end
            if (i_load_start) begin
                beat_cnt    <= '0;
                asm_q       <= '0;
                back_lines  <= '0;
                load_done_q <= 1'b0;
                load_err_q  <= 1'b0;
            end else if (beat_fire) begin
                if (line_end) begin
                    beat_cnt   <= '0;
                    asm_q      <= '0;
                    back_lines <= back_lines + 1'b1;
                    if (finish_ok && !finish_err) begin
                        load_done_q <= 1'b1;
                    end
                    if (finish_err) begin
                        load_err_q <= 1'b1;
                    end
                end else begin
                    beat_cnt <= beat_cnt + 1'b1;
                    asm_q    <= asm_next;
                end
            end
        end
    end

    wbuf_bank_ram #(
        .W     (LINE_W),
        .DEPTH (BANK_DEPTH),
        .AW    (AW)
    ) u_bank0 (
        .clk   (clk),
        .we    (we0),
        .waddr (back_lines[AW-1:0]),
        .wdata (wr_line),
        .re    (i_read_en),
        .raddr (i_read_addr),
        .rdata (rdata0)
    );

    wbuf_bank_ram #(
        .W     (LINE_W),
        .DEPTH (BANK_DEPTH),
        .AW    (AW)
    ) u_bank1 (
        .clk   (clk),
        .we    (we1),
        .waddr (back_lines[AW-1:0]),
        .wdata (wr_line),
        .re    (i_read_en),
        .raddr (i_read_addr),
        .rdata (rdata1)
    );

    assign rd_oob = ({1'b0, i_read_addr} >= active_lines);

    // Read-side qualifiers captured at issue so a read in the swap cycle sees the old bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_sel_q     <= 1'b0;
            rd_zero_q    <= 1'b1;
            read_valid_q <= 1'b0;
            read_oob_q   <= 1'b0;
        end else begin
            read_valid_q <= i_read_en;
            read_oob_q   <= i_read_en && rd_oob;
            if (i_read_en) begin
                rd_sel_q  <= active_bank;
                rd_zero_q <= rd_oob;
            end
        end
    end

    // RAM outputs and selects only move on a read, so the packed word holds between reads.
    assign o_kernels_packed = rd_zero_q ? '0 : (rd_sel_q ? rdata1 : rdata0);

endmodule

// File: tb/tb_weight_pingpong_buffer.sv
// tb/tb_weight_pingpong_buffer.sv - randomized directed bench with a line-level reference model
module tb_weight_pingpong_buffer;

    localparam int AXW = 64;
    localparam int LW  = 1152;
    localparam int NB  = 18;

    logic           clk = 1'b0;
    logic           rst;
    logic           tvalid;
    logic [AXW-1:0] tdata;
    logic           tlast;
    logic           load_start;
    logic           swap;
    logic           read_en;
    logic [8:0]     read_addr;

    logic           a_tready, a_done, a_err, a_act, a_rv, a_oob;
    logic [9:0]     a_lines;
    logic [LW-1:0]  a_kp;
    logic           b_tready, b_done, b_err, b_act, b_rv, b_oob;
    logic [2:0]     b_lines;
    logic [LW-1:0]  b_kp;

    int checks = 0;
    int errors = 0;

    logic [LW-1:0] mb [2][0:15];
    int            mlines [2];
    int            m_active;
    logic [LW-1:0] cur;
    int            slot;

    always #5 clk = ~clk;

    weight_pingpong_buffer u_dut_a (
        .clk (clk), .rst (rst),
        .s_axis_tvalid (tvalid), .s_axis_tready (a_tready), .s_axis_tdata (tdata), .s_axis_tlast (tlast),
        .i_load_start (load_start), .i_swap (swap),
        .o_load_done (a_done), .o_load_err (a_err), .o_back_lines (a_lines), .o_active_bank (a_act),
        .i_read_en (read_en), .i_read_addr (read_addr),
        .o_kernels_packed (a_kp), .o_read_valid (a_rv), .o_read_oob (a_oob)
    );

    weight_pingpong_buffer #(.BANK_DEPTH(4)) u_dut_b (
        .clk (clk), .rst (rst),
        .s_axis_tvalid (tvalid), .s_axis_tready (b_tready), .s_axis_tdata (tdata), .s_axis_tlast (tlast),
        .i_load_start (load_start), .i_swap (swap),
        .o_load_done (b_done), .o_load_err (b_err), .o_back_lines (b_lines), .o_active_bank (b_act),
        .i_read_en (read_en), .i_read_addr (read_addr[1:0]),
        .o_kernels_packed (b_kp), .o_read_valid (b_rv), .o_read_oob (b_oob)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        int bad;
        bad = 0;
        for (int b = NB - 1; b >= 0; b--) begin
            if (obs[b*AXW +: AXW] !== exp[b*AXW +: AXW]) bad = b;
        end
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s beat=%0d observed=%h expected=%h", tag, bad,
                   obs[bad*AXW +: AXW], exp[bad*AXW +: AXW]);
        end
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        mlines[1 - m_active] = 0;
        cur  = '0;
        slot = 0;
    endtask

    // Reference: a line is the beats laid end to end from bit 0, closed at NB beats or tlast.
    task automatic model_beat(input logic [AXW-1:0] d, input logic last);
        int bk;
        bk = 1 - m_active;
        cur[slot*AXW +: AXW] = d;
        slot++;
        if (slot == NB || last) begin
            mb[bk][mlines[bk]] = cur;
            mlines[bk]++;
            cur  = '0;
            slot = 0;
        end
    endtask

    task automatic send_beat(input logic [AXW-1:0] d, input logic last);
        int n;
        tvalid = 1'b1;
        tdata  = d;
        tlast  = last;
        n = 0;
        while (!a_tready && n < 50) begin
            tick();
            n++;
        end
        check("tready_wait", a_tready, 1);
        tick();
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic load_beats(input int n, input bit gaps);
        logic [AXW-1:0] d;
        logic           last;
        start_load();
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 3)) tick();
            d    = {$urandom, $urandom};
            last = (i == n - 1);
            send_beat(d, last);
            model_beat(d, last);
        end
    endtask

    task automatic do_swap();
        swap = 1'b1;
        tick();
        swap = 1'b0;
        m_active = 1 - m_active;
    endtask

    task automatic read_chk(input int addr, input bit exp_oob, input string tag);
        logic [LW-1:0] exp;
        read_en   = 1'b1;
        read_addr = 9'(addr);
        tick();
        read_en = 1'b0;
        exp = exp_oob ? '0 : mb[m_active][addr];
        check({tag, "_valid"}, a_rv, 1);
        check({tag, "_oob"}, a_oob, exp_oob);
        check_line({tag, "_data"}, a_kp, exp);
    endtask

    initial begin
        logic [LW-1:0] old_line;
        logic [LW-1:0] held;
        int            acc;

        rst = 1'b1; tvalid = 1'b0; tdata = '0; tlast = 1'b0;
        load_start = 1'b0; swap = 1'b0; read_en = 1'b0; read_addr = '0;
        m_active = 0; mlines[0] = 0; mlines[1] = 0; cur = '0; slot = 0;
        repeat (3) tick();

        check("rst_tready", a_tready, 0);
        check("rst_done", a_done, 0);
        check("rst_err", a_err, 0);
        check("rst_lines", a_lines, 0);
        check("rst_active", a_act, 0);
        check("rst_valid", a_rv, 0);
        check("rst_oob", a_oob, 0);
        check_line("rst_kp", a_kp, '0);
        rst = 1'b0;
        tick();

        // Full two-line layer into bank1, then swap it in.
        load_beats(36, 1'b0);
        check("l1_done", a_done, 1);
        check("l1_lines", a_lines, 2);
        check("l1_err", a_err, 0);
        check("l1_tready_off", a_tready, 0);
        do_swap();
        check("l1_active", a_act, 1);
        check("l1_done_clr", a_done, 0);
        read_chk(0, 1'b0, "l1_rd0");
        read_chk(1, 1'b0, "l1_rd1");
        held = mb[m_active][1];
        tick();
        check("l1_valid_drop", a_rv, 0);
        check_line("l1_hold", a_kp, held);

        // Ping-pong: core keeps reading bank1 while bank0 fills.
        start_load();
        for (int i = 0; i < 36; i++) begin
            logic [AXW-1:0] d;
            d = {$urandom, $urandom};
            send_beat(d, i == 35);
            model_beat(d, i == 35);
            read_chk(i % 2, 1'b0, "pp_rd_active");
            if (i == 10) begin
                swap = 1'b1;
                tick();
                swap = 1'b0;
                check("pp_swap_ignored", a_act, 1);
            end
        end
        check("pp_done", a_done, 1);
        old_line  = mb[m_active][0];
        read_en   = 1'b1;
        read_addr = 9'd0;
        swap      = 1'b1;
        tick();
        read_en = 1'b0;
        swap    = 1'b0;
        m_active = 1 - m_active;
        check_line("pp_swap_cycle_read", a_kp, old_line);
        check("pp_active", a_act, 0);
        read_chk(0, 1'b0, "pp_new0");
        read_chk(1, 1'b0, "pp_new1");

        // Short final line: tlast on beat 5 of line 0.
        load_beats(6, 1'b0);
        check("part_err", a_err, 1);
        check("part_lines", a_lines, 1);
        check("part_done", a_done, 0);
        do_swap();
        check("part_active", a_act, 1);
        read_chk(0, 1'b0, "part_rd0");
        read_chk(1, 1'b0 || 1'b1, "part_oob1");

        // Random tvalid gaps, then an out-of-range read.
        load_beats(36, 1'b1);
        check("bp_done", a_done, 1);
        check("bp_lines", a_lines, 2);
        do_swap();
        read_chk(0, 1'b0, "bp_rd0");
        read_chk(1, 1'b0, "bp_rd1");
        read_chk(2, 1'b1, "bp_oob2");
        read_chk(511, 1'b1, "bp_oob511");

        // Swap and start together in DONE: swap first, load goes to the old active bank.
        load_beats(18, 1'b0);
        check("ss_done", a_done, 1);
        load_start = 1'b1;
        swap       = 1'b1;
        tick();
        load_start = 1'b0;
        swap       = 1'b0;
        m_active = 1 - m_active;
        mlines[1 - m_active] = 0;
        cur = '0;
        slot = 0;
        check("ss_active", a_act, 1);
        check("ss_tready", a_tready, 1);
        check("ss_lines", a_lines, 0);
        read_chk(0, 1'b0, "ss_rd_swapped");
        for (int i = 0; i < 18; i++) begin
            logic [AXW-1:0] d;
            d = {$urandom, $urandom};
            send_beat(d, i == 17);
            model_beat(d, i == 17);
        end
        do_swap();
        check("ss_active2", a_act, 0);
        read_chk(0, 1'b0, "ss_rd_new");

        // Reset in the middle of a load.
        start_load();
        for (int i = 0; i < 10; i++) send_beat({$urandom, $urandom}, 1'b0);
        tvalid = 1'b1;
        rst    = 1'b1;
        tick();
        tvalid = 1'b0;
        check("mr_tready", a_tready, 0);
        check("mr_done", a_done, 0);
        check("mr_err", a_err, 0);
        check("mr_lines", a_lines, 0);
        check("mr_active", a_act, 0);
        check("mr_valid", a_rv, 0);
        check("mr_oob", a_oob, 0);
        check_line("mr_kp", a_kp, '0);
        rst = 1'b0;
        m_active = 0; mlines[0] = 0; mlines[1] = 0;
        tick();
        load_beats(18, 1'b1);
        check("mr_fresh_done", a_done, 1);
        check("mr_fresh_lines", a_lines, 1);
        do_swap();
        check("mr_fresh_active", a_act, 1);
        read_chk(0, 1'b0, "mr_rd0");
        read_chk(1, 1'b1, "mr_oob1");

        // Overflow on the 4-line instance: five lines offered, no tlast.
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        acc = 0;
        tvalid = 1'b1;
        tlast  = 1'b0;
        for (int c = 0; c < 100; c++) begin
            tdata = {$urandom, $urandom};
            if (b_tready) acc++;
            tick();
        end
        tvalid = 1'b0;
        check("ov_accepted", 64'(acc), 72);
        check("ov_tready", b_tready, 0);
        check("ov_err", b_err, 1);
        check("ov_lines", b_lines, 4);
        check("ov_done", b_done, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
